// File: rtl/pulse_dec_pkg.sv
// Shared types for the remote-control pulse frame decoder.
// FSM states and pulse-width classes.
package pulse_dec_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK
  } state_t;

  typedef enum logic [1:0] {
    SYNC,
    ZERO,
    ONE,
    BAD
  } pclass_t;

endpackage

// File: rtl/sync_edge_det.sv
// 2-FF synchroniser for an asynchronous pin plus
// single-cycle rise/fall strobes on the synced level.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic lvl_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      lvl_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      lvl_q  <= meta_q;
      prev_q <= lvl_q;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = lvl_q & ~prev_q;
  assign fall_o = ~lvl_q & prev_q;

endmodule

// File: rtl/pulse_frame_decoder.sv
// Pulse-width frame decoder: classifies high pulses as SYNC/0/1,
// assembles a frame LSB-first and emits the key field.
module pulse_frame_decoder
  import pulse_dec_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int T0_CYC     = 23000,
  parameter int T1_CYC     = 40000,
  parameter int SYNC_CYC   = 60000,
  parameter int TOL_CYC    = 2000,
  parameter int GAP_CYC    = 65000,
  parameter int FRAME_BITS = 32,
  parameter int DATA_LSB   = 16,
  parameter int DATA_W     = 8,
  parameter int CHECK_INV  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sinal,
  output logic [DATA_W-1:0] key_code,
  output logic              key_valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int IDX_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] GAP_LIM = CNT_W'(GAP_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 1);

  logic s;
  logic rise;
  logic fall;

  sync_edge_det u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (sinal),
    .lvl_o  (s),
    .rise_o (rise),
    .fall_o (fall)
  );

  logic [CNT_W-1:0]      width_q, width_d;
  logic [CNT_W-1:0]      gap_q, gap_d;
  state_t                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic [DATA_W-1:0]     key_q;
  logic                  valid_q;
  logic                  err_q;
  pclass_t               pc;
  logic [DATA_W-1:0]     key_f;
  logic                  inv_ok;

  function automatic logic near(
    input logic [CNT_W-1:0] w,
    input int               n
  );
    int wi;
    wi = int'(w);
    return (wi >= n - TOL_CYC) && (wi <= n + TOL_CYC);
  endfunction

  // Windows never overlap, so at most one arm can match.
  always_comb begin
    pc = BAD;
    unique case (1'b1)
      near(width_q, SYNC_CYC): pc = SYNC;
      near(width_q, T1_CYC):   pc = ONE;
      near(width_q, T0_CYC):   pc = ZERO;
      default:                 pc = BAD;
    endcase
  end

  always_comb begin
    width_d = width_q;
    if (rise)
      width_d = CNT_W'(1);
    else if (s && width_q != CNT_MAX)
      width_d = width_q + CNT_W'(1);
    gap_d = gap_q;
    if (fall)
      gap_d = CNT_W'(1);
    else if (!s && state_q == RECV && gap_q != CNT_MAX)
      gap_d = gap_q + CNT_W'(1);
  end

  assign key_f = frame_q[DATA_LSB +: DATA_W];

  if (CHECK_INV != 0) begin : g_inv
    assign inv_ok =
      (frame_q[DATA_LSB+DATA_W +: DATA_W] == ~key_f);
  end else begin : g_noinv
    assign inv_ok = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q <= '0;
      gap_q   <= '0;
      state_q <= IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      width_q <= width_d;
      gap_q   <= gap_d;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fall && pc == SYNC) begin
            state_q <= RECV;
            idx_q   <= '0;
          end
        end
        RECV: begin
          if (fall) begin
            unique case (pc)
              SYNC: idx_q <= '0;
              ZERO, ONE: begin
                // LSB-first: first bit ends up in frame_q[0]
                frame_q <= {pc == ONE, frame_q[FRAME_BITS-1:1]};
                idx_q   <= idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST)
                  state_q <= CHECK;
              end
              default: begin
                err_q   <= 1'b1;
                state_q <= IDLE;
              end
            endcase
          end else if (!s && gap_q >= GAP_LIM) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        CHECK: begin
          if (inv_ok) begin
            key_q   <= key_f;
            valid_q <= 1'b1;
          end else begin
            err_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign key_code  = key_q;
  assign key_valid = valid_q;
  assign frame_err = err_q;
  assign busy      = (state_q == RECV);

endmodule

// File: tb/tb_pulse_frame_decoder.sv
// Bench for pulse_frame_decoder: width-window table, hand-built
// corner sequences and random frames against a pulse-level model.
module tb_pulse_frame_decoder;

  localparam int T0  = 4;
  localparam int T1  = 12;
  localparam int SY  = 24;
  localparam int TOL = 1;
  localparam int GAP = 40;
  localparam int FB  = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sinal = 1'b0;
  logic [7:0] key_code;
  logic       key_valid;
  logic       frame_err;
  logic       busy;

  pulse_frame_decoder #(
    .CNT_W(16), .T0_CYC(T0), .T1_CYC(T1), .SYNC_CYC(SY),
    .TOL_CYC(TOL), .GAP_CYC(GAP), .FRAME_BITS(FB),
    .DATA_LSB(0), .DATA_W(8), .CHECK_INV(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sinal(sinal),
    .key_code(key_code), .key_valid(key_valid),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         v;
    bit         e;
    logic [7:0] key;
    int         t;
  } ev_t;

  ev_t dq[$];
  ev_t eq[$];

  always @(negedge clk)
    if (rst_n && (key_valid || frame_err))
      dq.push_back('{key_valid, frame_err, key_code, cyc});

  int vectors = 0;
  int fails = 0;

  // Pulse-level reference model
  bit         m_recv = 1'b0;
  int         m_n = 0;
  logic [15:0] m_frame = '0;
  logic [7:0] m_key = '0;
  int         last_fall = 0;

  function automatic int cls(input int h);
    if (h >= SY - TOL && h <= SY + TOL) return 0;
    if (h >= T1 - TOL && h <= T1 + TOL) return 2;
    if (h >= T0 - TOL && h <= T0 + TOL) return 1;
    return 3;
  endfunction

  task automatic model(input int h, input int l, input int f);
    int c;
    c = cls(h);
    if (!m_recv) begin
      if (c == 0) begin
        m_recv = 1'b1;
        m_n = 0;
      end
    end else if (c == 0) begin
      m_n = 0;
    end else if (c == 3) begin
      eq.push_back('{1'b0, 1'b1, 8'h00, f + 3});
      m_recv = 1'b0;
    end else begin
      m_frame[m_n] = (c == 2);
      m_n++;
      if (m_n == FB) begin
        m_recv = 1'b0;
        if (m_frame[15:8] == ~m_frame[7:0]) begin
          m_key = m_frame[7:0];
          eq.push_back('{1'b1, 1'b0, m_key, f + 4});
        end else begin
          eq.push_back('{1'b0, 1'b1, 8'h00, f + 4});
        end
      end
    end
    // low long enough for the gap counter to hit its limit
    if (m_recv && l >= GAP + 2) begin
      eq.push_back('{1'b0, 1'b1, 8'h00, f + GAP + 3});
      m_recv = 1'b0;
    end
  endtask

  task automatic pulse(input int h, input int l);
    sinal = 1'b1;
    repeat (h) @(posedge clk);
    #1;
    sinal = 1'b0;
    last_fall = cyc;
    model(h, l, last_fall);
    repeat (l) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic flush(input string nm);
    repeat (GAP + 12) @(posedge clk);
    #1;
    foreach (eq[i]) begin
      vectors++;
      if (i >= dq.size()) begin
        fails++;
        $display("FAIL %s[%0d]: got no strobe, expected v=%0b e=%0b key=%0h t=%0d",
                 nm, i, eq[i].v, eq[i].e, eq[i].key, eq[i].t);
      end else if (dq[i].v != eq[i].v || dq[i].e != eq[i].e ||
                   dq[i].t != eq[i].t ||
                   (eq[i].v && dq[i].key != eq[i].key)) begin
        fails++;
        $display("FAIL %s[%0d]: got v=%0b e=%0b key=%0h t=%0d, expected v=%0b e=%0b key=%0h t=%0d",
                 nm, i, dq[i].v, dq[i].e, dq[i].key, dq[i].t,
                 eq[i].v, eq[i].e, eq[i].key, eq[i].t);
      end
    end
    vectors++;
    if (dq.size() != eq.size()) begin
      fails++;
      $display("FAIL %s_count: got %0d strobes, expected %0d",
               nm, dq.size(), eq.size());
    end
    eq.delete();
    dq.delete();
  endtask

  task automatic send_frame(input logic [15:0] word, input int bad_i,
                            input int bad_w, input int lo);
    int h;
    pulse(SY, 4);
    chk("busy_after_sync", {31'd0, busy}, {31'd0, m_recv});
    for (int i = 0; i < FB; i++) begin
      h = word[i] ? T1 : T0;
      if (i == bad_i) h = bad_w;
      pulse(h, lo);
    end
  endtask

  function automatic int bad_width(input int k);
    case (k)
      0: return 2;
      1: return 6;
      2: return 8;
      3: return 10;
      4: return 14;
      default: return 18;
    endcase
  endfunction

  typedef struct {
    int w;
    int ofs;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [7:0]  k;
    logic [15:0] word;
    int r, pos, h, l;

    tbl = '{
      '{3, GAP + 3}, '{4, GAP + 3}, '{5, GAP + 3},
      '{11, GAP + 3}, '{12, GAP + 3}, '{13, GAP + 3},
      '{23, GAP + 3}, '{24, GAP + 3}, '{25, GAP + 3},
      '{2, 3}, '{6, 3}, '{10, 3}, '{14, 3}
    };

    repeat (3) @(posedge clk);
    #1;
    chk("rst_key", {24'd0, key_code}, 32'h0);
    chk("rst_valid", {31'd0, key_valid}, 32'h0);
    chk("rst_err", {31'd0, frame_err}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send_frame(16'h5AA5, -1, 0, 4);
    flush("good_5aa5");
    chk("key_5aa5", {24'd0, key_code}, 32'hA5);
    chk("busy_idle", {31'd0, busy}, 32'h0);

    send_frame(16'h5AA5, 3, 8, 4);
    flush("bad_bit3");
    chk("key_hold_bad", {24'd0, key_code}, 32'hA5);

    send_frame({8'h5B, 8'hA5}, -1, 0, 4);
    flush("inv_mismatch");
    chk("key_hold_inv", {24'd0, key_code}, 32'hA5);

    pulse(SY, 4);
    for (int i = 0; i < 5; i++)
      pulse((16'h5AA5 >> i) & 1 ? T1 : T0, i == 4 ? 45 : 4);
    flush("gap_timeout");
    send_frame(16'h6996, -1, 0, 4);
    flush("after_timeout");
    chk("key_6996", {24'd0, key_code}, 32'h96);

    foreach (tbl[i]) begin
      pulse(SY, 4);
      pulse(tbl[i].w, 45);
      repeat (GAP + 12) @(posedge clk);
      #1;
      vectors++;
      if (dq.size() != 1 || !dq[0].e || dq[0].v ||
          dq[0].t - last_fall != tbl[i].ofs) begin
        fails++;
        $display("FAIL width_%0d: got %0d strobes (first e=%0b ofs=%0d), expected one err at ofs %0d",
                 tbl[i].w, dq.size(),
                 dq.size() > 0 ? dq[0].e : 1'b0,
                 dq.size() > 0 ? dq[0].t - last_fall : -1,
                 tbl[i].ofs);
      end
      dq.delete();
      eq.delete();
    end

    pulse(SY, 4);
    for (int i = 0; i < 9; i++)
      pulse((16'h5AA5 >> i) & 1 ? T1 : T0, 4);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_key", {24'd0, key_code}, 32'h0);
    chk("mid_rst_valid", {31'd0, key_valid}, 32'h0);
    chk("mid_rst_err", {31'd0, frame_err}, 32'h0);
    chk("mid_rst_busy", {31'd0, busy}, 32'h0);
    eq.delete();
    dq.delete();
    m_recv = 1'b0;
    m_key = '0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    pulse(T0, 4);
    pulse(T1, 4);
    pulse(8, 4);
    pulse(2, 4);
    flush("idle_noise");
    chk("key_after_rst", {24'd0, key_code}, 32'h0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      k = 8'($urandom);
      word = {~k, k};
      pos = $urandom_range(0, FB - 1);
      if (r == 0) word[15:8] = word[15:8] ^ (8'h01 << $urandom_range(0, 7));
      if (r == 1) pulse($urandom_range(2, 30), $urandom_range(3, 30));
      pulse($urandom_range(SY - TOL, SY + TOL), $urandom_range(3, 30));
      for (int i = 0; i < FB; i++) begin
        h = word[i] ? $urandom_range(T1 - TOL, T1 + TOL)
                    : $urandom_range(T0 - TOL, T0 + TOL);
        l = $urandom_range(3, 30);
        if (r == 2 && i == pos) h = bad_width($urandom_range(0, 5));
        if (r == 3 && i == pos) l = $urandom_range(50, 60);
        pulse(h, l);
      end
      flush("random");
      chk("random_key", {24'd0, key_code}, {24'd0, m_key});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
